sweep_ctrl: RTL and testbench

- Sequencer that drives an 8-bit up/down counter datapath as a bounded ping-pong sweep between programmable limits lo and hi.
- Holds at each endpoint for a programmable dwell time, repeats for a programmed number of round trips (or forever), then signals completion.
- Sits between the host/config logic and the counter. It owns the counter's enable, direction and load, so the counter never wraps.

---
 rtl/sweep_pkg.sv | 14 +
 rtl/sweep_if.sv | 30 +++
 rtl/sweep_counter.sv | 21 ++
 rtl/sweep_ctrl.sv | 115 +++++++++++
 tb/tb_sweep_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sweep_pkg.sv
// Shared types and default sizes for the ping-pong sweep sequencer.
package sweep_pkg;
    localparam int SW_WIDTH   = 8;
    localparam int SW_DWELL_W = 4;
    localparam int SW_TRIP_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        DWELL_HI,
        DOWN,
        DWELL_LO
    } state_t;
endpackage

// File: rtl/sweep_if.sv
// Host-side sweep bus: configuration and command in, counter status out.
interface sweep_if
    import sweep_pkg::*;
#(
    parameter int WIDTH   = SW_WIDTH,
    parameter int DWELL_W = SW_DWELL_W,
    parameter int TRIP_W  = SW_TRIP_W
);
    logic               start;
    logic               stop;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi;
    logic [DWELL_W-1:0] dwell;
    logic [TRIP_W-1:0]  trips;
    logic [WIDTH-1:0]   count;
    logic               dir;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, stop, lo, hi, dwell, trips,
        input  count, dir, busy, done, err
    );

    modport slave (
        input  start, stop, lo, hi, dwell, trips,
        output count, dir, busy, done, err
    );
endinterface

// File: rtl/sweep_counter.sv
// Up/down counter datapath; load has priority over counting.
module sweep_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
    end
endmodule

// File: rtl/sweep_ctrl.sv
// Ping-pong sweep sequencer: walks the counter lo->hi->lo with endpoint
// dwell, for a programmed number of round trips or forever.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH   = SW_WIDTH,
    parameter int DWELL_W = SW_DWELL_W,
    parameter int TRIP_W  = SW_TRIP_W
) (
    input logic   clk,
    input logic   reset_n,
    sweep_if.slave bus
);
    state_t             state;
    logic [WIDTH-1:0]   count;
    logic [WIDTH-1:0]   lo_s, hi_s;
    logic [DWELL_W-1:0] dwell_s, dwell_cnt;
    logic [TRIP_W-1:0]  trips_s, trip_cnt;
    logic               dir_q, busy_q, done_q, err_q;
    logic               start_ok;

    assign start_ok = (state == IDLE) && bus.start && !bus.stop && (bus.lo < bus.hi);

    // The step enable follows the current state, so the edge that samples
    // stop still completes the step already in progress.
    sweep_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (start_ok),
        .en       (state == UP || state == DOWN),
        .up       (state == UP),
        .load_val (bus.lo),
        .count    (count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            dir_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            lo_s      <= '0;
            hi_s      <= '0;
            dwell_s   <= '0;
            trips_s   <= '0;
            dwell_cnt <= '0;
            trip_cnt  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state != IDLE && bus.stop) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            lo_s     <= bus.lo;
                            hi_s     <= bus.hi;
                            dwell_s  <= bus.dwell;
                            trips_s  <= bus.trips;
                            trip_cnt <= '0;
                            dir_q    <= 1'b1;
                            busy_q   <= 1'b1;
                            state    <= UP;
                        end else if (bus.start && !bus.stop) begin
                            err_q <= 1'b1;
                        end
                    end
                    UP: begin
                        if (count + WIDTH'(1) == hi_s) begin
                            dwell_cnt <= '0;
                            state     <= DWELL_HI;
                        end
                    end
                    DWELL_HI: begin
                        if (dwell_cnt == dwell_s) begin
                            dir_q <= 1'b0;
                            state <= DOWN;
                        end else begin
                            dwell_cnt <= dwell_cnt + DWELL_W'(1);
                        end
                    end
                    DOWN: begin
                        if (count - WIDTH'(1) == lo_s) begin
                            dwell_cnt <= '0;
                            trip_cnt  <= trip_cnt + TRIP_W'(1);
                            state     <= DWELL_LO;
                        end
                    end
                    DWELL_LO: begin
                        if (dwell_cnt != dwell_s) begin
                            dwell_cnt <= dwell_cnt + DWELL_W'(1);
                        end else if (trips_s != '0 && trip_cnt == trips_s) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            dir_q <= 1'b1;
                            state <= UP;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.count = count;
    assign bus.dir   = dir_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: the model expands each accepted start into the full
// list of per-cycle outputs, and every cycle is compared against it.
module tb_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    sweep_if bus ();
    sweep_ctrl dut (.clk(clk), .reset_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int c; bit d; bit b; bit dn; } ent_t;
    ent_t q[$];
    int m_count = 0;
    bit m_dir = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_cont = 1'b0;
    int m_lo, m_hi, m_dw;

    function automatic void push(int c, bit d, bit b, bit dn);
        ent_t e;
        e.c = c; e.d = d; e.b = b; e.dn = dn;
        q.push_back(e);
    endfunction

    function automatic void add_trip();
        for (int v = m_lo; v < m_hi; v++) push(v, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k <= m_dw; k++) push(m_hi, 1'b1, 1'b1, 1'b0);
        for (int v = m_hi; v > m_lo; v--) push(v, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k <= m_dw; k++) push(m_lo, 1'b0, 1'b1, 1'b0);
    endfunction

    function automatic void step();
        ent_t e;
        e = q.pop_front();
        m_count = e.c; m_dir = e.d; m_busy = e.b; m_done = e.dn;
        if (m_cont && q.size() < 600) add_trip();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_count = 0; m_dir = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (q.size() != 0) begin
                if (bus.stop) begin
                    m_count = q[0].c;
                    m_busy  = 1'b0;
                    q.delete();
                end else begin
                    step();
                end
            end else if (bus.start && !bus.stop) begin
                if (int'(bus.lo) < int'(bus.hi)) begin
                    m_lo = int'(bus.lo); m_hi = int'(bus.hi); m_dw = int'(bus.dwell);
                    m_cont = (bus.trips == 8'd0);
                    for (int t = 0; t < (m_cont ? 2 : int'(bus.trips)); t++) add_trip();
                    if (!m_cont) push(m_lo, 1'b0, 1'b0, 1'b1);
                    step();
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_count", int'(bus.count), m_count);
            chk("cyc_dir",   int'(bus.dir),   int'(m_dir));
            chk("cyc_busy",  int'(bus.busy),  int'(m_busy));
            chk("cyc_done",  int'(bus.done),  int'(m_done));
            chk("cyc_err",   int'(bus.err),   int'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    int exp1[9] = '{3, 4, 5, 6, 6, 5, 4, 3, 3};
    int exp6[5] = '{254, 255, 255, 254, 254};

    task automatic do_start(input int l, input int h, input int dw, input int tr);
        @(negedge clk);
        bus.lo = 8'(l); bus.hi = 8'(h); bus.dwell = 4'(dw); bus.trips = 8'(tr);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            n++;
            @(negedge clk);
        end
        if (bus.busy) chk({nm, "_timeout"}, 1, 0);
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.stop = 1'b0;
        bus.lo = '0; bus.hi = '0; bus.dwell = '0; bus.trips = '0;
        repeat (2) @(negedge clk);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_dir",   int'(bus.dir),   1);
        chk("rst_busy",  int'(bus.busy),  0);
        chk("rst_done",  int'(bus.done),  0);
        chk("rst_err",   int'(bus.err),   0);
        #1 rst_n = 1'b1;

        // single trip
        do_start(3, 6, 0, 1);
        n = 0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t1_count%0d", i), int'(bus.count), exp1[i]);
            if (bus.busy) n++;
            if (i == 3) chk("t1_dir_hi", int'(bus.dir), 1);
            if (i == 4) chk("t1_dir_fall", int'(bus.dir), 0);
            if (i == 8) begin
                chk("t1_done", int'(bus.done), 1);
                chk("t1_busy_end", int'(bus.busy), 0);
            end
            @(negedge clk);
        end
        chk("t1_busy_time", n, 8);

        // rejection
        do_start(9, 9, 0, 1);
        chk("rej1_err", int'(bus.err), 1);
        chk("rej1_busy", int'(bus.busy), 0);
        chk("rej1_count", int'(bus.count), 3);
        @(negedge clk);
        chk("rej1_err_pulse", int'(bus.err), 0);
        do_start(10, 4, 0, 1);
        chk("rej2_err", int'(bus.err), 1);
        chk("rej2_busy", int'(bus.busy), 0);
        chk("rej2_count", int'(bus.count), 3);

        // dwell and repeat
        do_start(0, 2, 2, 2);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("t2_busy_time", n, 20);
        chk("t2_end_count", int'(bus.count), 0);

        // abort in continuous mode
        do_start(0, 255, 0, 0);
        n = 0;
        while (bus.count != 8'd100 && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("abort_reach", int'(n < 300), 1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_count", int'(bus.count), 101);
        chk("abort_dir", int'(bus.dir), 1);
        chk("abort_done", int'(bus.done), 0);
        @(negedge clk);
        chk("abort_hold", int'(bus.count), 101);
        do_start(5, 8, 1, 1);
        chk("restart_busy", int'(bus.busy), 1);
        wait_idle("restart", 100);
        chk("restart_end", int'(bus.count), 5);

        // async reset mid-DOWN
        do_start(40, 60, 1, 0);
        n = 0;
        while (!(bus.count == 8'd50 && bus.dir == 1'b0) && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("rst_reach", int'(n < 200), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", int'(bus.count), 0);
        chk("arst_dir", int'(bus.dir), 1);
        chk("arst_busy", int'(bus.busy), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        bus.lo = 8'd7; bus.hi = 8'd9; bus.dwell = 4'd0; bus.trips = 8'd1;
        bus.start = 1'b1; bus.stop = 1'b1;
        repeat (2) @(negedge clk);
        chk("ss_busy", int'(bus.busy), 0);
        chk("ss_err", int'(bus.err), 0);
        bus.stop = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ss_accept", int'(bus.busy), 1);
        chk("ss_count", int'(bus.count), 7);
        wait_idle("ss", 100);

        // ignore-while-busy with hi-lo=1
        do_start(254, 255, 0, 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t6_count%0d", i), int'(bus.count), exp6[i]);
            if (i == 4) chk("t6_done", int'(bus.done), 1);
            if (i < 4) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.lo = 8'($urandom_range(0, 255));
                bus.hi = 8'($urandom_range(0, 255));
                bus.dwell = 4'($urandom_range(0, 15));
                bus.trips = 8'($urandom_range(0, 255));
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            int l, h;
            l = $urandom_range(0, 255);
            h = l + $urandom_range(0, 12);
            if (h > 255) h = 255;
            if ($urandom_range(0, 7) == 0) h = $urandom_range(0, 255);
            bus.lo = 8'(l);
            bus.hi = 8'(h);
            bus.dwell = 4'($urandom_range(0, 3));
            bus.trips = 8'($urandom_range(0, 3));
            bus.start = ($urandom_range(0, 3) == 0);
            bus.stop = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.stop = 1'b1;
        repeat (2) @(negedge clk);
        bus.stop = 1'b0;
        chk("final_idle", int'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
